// File: rtl/multicycle_pkg.sv
// multicycle_pkg: opcodes, FSM states and mux-select encodings shared by control and datapath
package multicycle_pkg;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_LW = 4'h2;
  localparam logic [3:0] OP_SW = 4'h3;
  localparam logic [3:0] OP_LI = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_BEQZ = 4'h8;
  localparam logic [3:0] OP_JR = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_REL = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;
  localparam logic [1:0] RF_ALU = 2'b00;
  localparam logic [1:0] RF_MDR = 2'b01;
  localparam logic [1:0] RF_IMM = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  function automatic logic is_legal(input logic [3:0] op);
    return op inside {OP_NOP, OP_ADD, OP_LW, OP_SW, OP_LI, OP_SUB, OP_BEQZ, OP_JR, OP_HALT};
  endfunction
endpackage

// File: rtl/mc_ack_timer.sv
// mc_ack_timer: counts consecutive unacknowledged req cycles; expired pulses on the TIMEOUT-th (clk, rst, req, ack -> expired)
module mc_ack_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ack,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  logic [W-1:0] count;
  assign expired = req && !ack && count == LAST;
  always_ff @(posedge clk) begin
    if (rst || !req || ack || expired) count <= '0;
    else count <= count + 1'b1;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/exec/mem/wb sequencer driving datapath strobes, req/ack memory handshake, sticky error flags, retired count
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNTW = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [3:0] opcode,
  input  logic rd_zero,
  output logic imem_req,
  input  logic imem_ack,
  output logic dmem_req,
  output logic dmem_we,
  input  logic dmem_ack,
  output logic ir_we,
  output logic pc_we,
  output logic [1:0] pc_src,
  output logic alu_sub,
  output logic aluout_we,
  output logic mdr_we,
  output logic rf_we,
  output logic [1:0] rf_src,
  output logic busy,
  output logic halted,
  output logic illegal,
  output logic bus_err,
  output logic [CNTW-1:0] retired_cnt
);
  state_t state, next;
  logic expired, retire, set_ill, set_berr;
  // requests depend only on state so the timer's expired feeds back without a comb loop
  assign imem_req = state == S_FETCH;
  assign dmem_req = state == S_MEM;
  assign dmem_we = dmem_req && opcode == OP_SW;
  assign busy = state != S_IDLE && state != S_HALT;
  assign halted = state == S_HALT;
  mc_ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .rst(rst),
    .req(imem_req || dmem_req),
    .ack(imem_req ? imem_ack : dmem_ack),
    .expired(expired)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      illegal <= 1'b0;
      bus_err <= 1'b0;
      retired_cnt <= '0;
    end else begin
      state <= next;
      illegal <= illegal || set_ill;
      bus_err <= bus_err || set_berr;
      retired_cnt <= retired_cnt + CNTW'(retire);
    end
  end
  always_comb begin
    next = state;
    ir_we = 1'b0;
    pc_we = 1'b0;
    pc_src = PC_INC;
    alu_sub = 1'b0;
    aluout_we = 1'b0;
    mdr_we = 1'b0;
    rf_we = 1'b0;
    rf_src = RF_ALU;
    set_ill = 1'b0;
    set_berr = 1'b0;
    case (state)
      S_IDLE: next = start ? S_FETCH : S_IDLE;
      S_FETCH: begin
        ir_we = imem_ack;
        next = imem_ack ? S_DECODE : expired ? S_HALT : S_FETCH;
        set_berr = !imem_ack && expired;
      end
      S_DECODE: begin
        pc_we = 1'b1;
        set_ill = !is_legal(opcode);
        next = set_ill || opcode == OP_HALT ? S_HALT
             : opcode inside {OP_ADD, OP_SUB, OP_BEQZ, OP_JR} ? S_EXEC
             : opcode inside {OP_LW, OP_SW} ? S_MEM
             : opcode == OP_LI ? S_WB : S_FETCH;
      end
      S_EXEC: begin
        aluout_we = opcode inside {OP_ADD, OP_SUB};
        alu_sub = opcode == OP_SUB;
        pc_we = opcode == OP_JR || (opcode == OP_BEQZ && rd_zero);
        pc_src = opcode == OP_JR ? PC_REG : opcode == OP_BEQZ ? PC_REL : PC_INC;
        next = aluout_we ? S_WB : S_FETCH;
      end
      S_MEM: begin
        mdr_we = dmem_ack && opcode == OP_LW;
        next = dmem_ack ? (opcode == OP_LW ? S_WB : S_FETCH) : expired ? S_HALT : S_MEM;
        set_berr = !dmem_ack && expired;
      end
      S_WB: begin
        rf_we = 1'b1;
        rf_src = opcode == OP_LW ? RF_MDR : opcode == OP_LI ? RF_IMM : RF_ALU;
        next = S_FETCH;
      end
      default: next = S_HALT;
    endcase
  end
  // an instruction retires when control returns to FETCH after the fetch stage, or on a decoded HALT
  assign retire = (next == S_FETCH && state inside {S_DECODE, S_EXEC, S_MEM, S_WB})
               || (state == S_DECODE && opcode == OP_HALT);
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed-vector self-checking bench for multicycle_ctrl with TIMEOUT=4
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst, start, rd_zero, imem_ack, dmem_ack;
  logic [3:0] opcode;
  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_sub, aluout_we, mdr_we, rf_we;
  logic busy, halted, illegal, bus_err;
  logic [1:0] pc_src, rf_src;
  logic [15:0] retired_cnt;
  int checks = 0;
  int failures = 0;
  multicycle_ctrl #(.TIMEOUT(4), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .rd_zero(rd_zero),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_sub(alu_sub),
    .aluout_we(aluout_we), .mdr_we(mdr_we), .rf_we(rf_we), .rf_src(rf_src), .busy(busy),
    .halted(halted), .illegal(illegal), .bus_err(bus_err), .retired_cnt(retired_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; opcode = 4'h0; rd_zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    tick();
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_imem_req", imem_req, 0);
    check("rst_cnt", retired_cnt, 0);
    check("rst_flags", {halted, illegal, bus_err}, 0);
    imem_ack = 1'b1; dmem_ack = 1'b1;
    tick();
    check("idle_ack_ignored", {busy, ir_we, mdr_we}, 0);
    dmem_ack = 1'b0;
    start = 1'b1; opcode = 4'h1;
    tick();
    start = 1'b0; #1;
    check("add_fetch", {imem_req, ir_we, busy}, 3'b111);
    tick();
    check("add_decode", {pc_we, pc_src, imem_req}, 4'b1000);
    tick();
    check("add_exec", {aluout_we, alu_sub, rf_we}, 3'b100);
    tick();
    check("add_wb", {rf_we, rf_src}, 3'b100);
    tick();
    check("add_back_fetch", imem_req, 1);
    check("add_cnt", retired_cnt, 1);
    opcode = 4'h2;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check("lw_wait", {dmem_req, dmem_we, mdr_we}, 3'b100);
      tick();
    end
    dmem_ack = 1'b1; #1;
    check("lw_ack", {dmem_req, dmem_we, mdr_we, bus_err}, 4'b1010);
    tick();
    dmem_ack = 1'b0; #1;
    check("lw_wb", {rf_we, rf_src, dmem_req}, 4'b1010);
    tick();
    check("lw_cnt", retired_cnt, 2);
    opcode = 4'h8; rd_zero = 1'b1; #1;
    tick(); tick();
    check("beqz_taken", {pc_we, pc_src}, 3'b101);
    tick();
    check("beqz_t_fetch", {imem_req, retired_cnt}, {1'b1, 16'd3});
    rd_zero = 1'b0; #1;
    tick(); tick();
    check("beqz_not_taken", {pc_we, aluout_we}, 0);
    tick();
    check("beqz_nt_fetch", {imem_req, retired_cnt}, {1'b1, 16'd4});
    opcode = 4'h9; #1;
    tick(); tick();
    check("jr_exec", {pc_we, pc_src}, 3'b110);
    tick();
    check("jr_cnt", retired_cnt, 5);
    opcode = 4'h3; #1;
    tick(); tick();
    dmem_ack = 1'b1; #1;
    check("sw_mem", {dmem_req, dmem_we, mdr_we}, 3'b110);
    tick();
    dmem_ack = 1'b0; #1;
    check("sw_fetch", {imem_req, retired_cnt}, {1'b1, 16'd6});
    opcode = 4'h4; #1;
    tick(); tick();
    check("li_wb", {rf_we, rf_src}, 3'b110);
    tick();
    check("li_cnt", retired_cnt, 7);
    opcode = 4'h5; #1;
    tick(); tick();
    check("sub_exec", {aluout_we, alu_sub}, 2'b11);
    tick();
    check("sub_wb", {rf_we, rf_src}, 3'b100);
    tick();
    check("sub_cnt", retired_cnt, 8);
    opcode = 4'h0; #1;
    tick();
    imem_ack = 1'b0; #1;
    tick();
    check("nop_cnt", retired_cnt, 9);
    for (int i = 0; i < 3; i++) begin
      check("late_ack_wait", {imem_req, ir_we}, 2'b10);
      tick();
    end
    imem_ack = 1'b1; #1;
    check("late_ack_ir", ir_we, 1);
    tick();
    imem_ack = 1'b0; #1;
    check("late_ack_no_err", {bus_err, halted}, 0);
    tick();
    check("late_ack_cnt", retired_cnt, 10);
    for (int i = 0; i < 4; i++) begin
      check("timeout_wait", {imem_req, bus_err}, 2'b10);
      tick();
    end
    check("timeout_halt", {bus_err, halted, busy, imem_req}, 4'b1100);
    check("timeout_cnt", retired_cnt, 10);
    start = 1'b1;
    tick();
    start = 1'b0; #1;
    check("halt_start_ignored", {halted, busy}, 2'b10);
    do_reset();
    check("reset_clears", {bus_err, halted, retired_cnt}, 0);
    start = 1'b1; opcode = 4'h7; imem_ack = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("illegal_halt", {illegal, halted, retired_cnt}, {2'b11, 16'd0});
    do_reset();
    start = 1'b1; opcode = 4'hF;
    tick();
    start = 1'b0;
    tick(); tick();
    check("halt_op", {illegal, halted, retired_cnt}, {2'b01, 16'd1});
    start = 1'b1;
    tick();
    start = 1'b0; #1;
    check("halt_op_stays", {halted, busy}, 2'b10);
    do_reset();
    start = 1'b1; opcode = 4'h2;
    tick();
    start = 1'b0;
    tick(); tick();
    check("mid_mem_req", dmem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; dmem_ack = 1'b1; #1;
    check("mid_rst_outs", {dmem_req, mdr_we, busy, rf_we, halted, illegal, bus_err}, 0);
    check("mid_rst_cnt", retired_cnt, 0);
    tick();
    check("late_dack_ignored", {busy, dmem_req, mdr_we}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
